// File: rtl/washing_machine_timer_if.sv
// Timer request/response bundle between the washer controller (master) and the phase timer (slave).
// Request is level-held TIMER_EN plus TIMER_SEL; response is a one-cycle TIMER_DONE with status.
interface washing_machine_timer_if #(
  parameter int CNT_W = 16
);
  logic             TIMER_EN;
  logic [1:0]       TIMER_SEL;
  logic             TIMER_DONE;
  logic             TIMER_BUSY;
  logic [CNT_W-1:0] TIMER_REMAIN;

  modport master (
    output TIMER_EN,
    output TIMER_SEL,
    input  TIMER_DONE,
    input  TIMER_BUSY,
    input  TIMER_REMAIN
  );

  modport slave (
    input  TIMER_EN,
    input  TIMER_SEL,
    output TIMER_DONE,
    output TIMER_BUSY,
    output TIMER_REMAIN
  );
endinterface

// File: rtl/washing_machine_timer.sv
// Phase timer: prescaler turns cycles into units, down-counter pulses TIMER_DONE after DUR(sel)*PRESCALE edges.
// All outputs registered; start, abort and restart take effect at the edge where they are sampled.
module washing_machine_timer #(
  parameter int PRESCALE = 50,
  parameter int CNT_W    = 16,
  parameter int DUR_00   = 1,
  parameter int DUR_01   = 600,
  parameter int DUR_10   = 900,
  parameter int DUR_11   = 300
) (
  input  logic                         CLK,
  input  logic                         RST,
  washing_machine_timer_if.slave       tif
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  // Truncate to counter width, and never load zero so a run always produces a pulse.
  function automatic logic [CNT_W-1:0] eff_dur(input int d);
    logic [CNT_W-1:0] t;
    t = CNT_W'(d);
    return (t == '0) ? CNT_W'(1) : t;
  endfunction

  localparam logic [CNT_W-1:0] D00 = eff_dur(DUR_00);
  localparam logic [CNT_W-1:0] D01 = eff_dur(DUR_01);
  localparam logic [CNT_W-1:0] D10 = eff_dur(DUR_10);
  localparam logic [CNT_W-1:0] D11 = eff_dur(DUR_11);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  state_t           r_state;
  logic [PS_W-1:0]  r_presc;
  logic [CNT_W-1:0] r_remain;
  logic [1:0]       r_sel;
  logic             r_done;
  logic             r_busy;

  logic [CNT_W-1:0] w_load_dur;
  logic             w_sel_chg;
  logic             w_tick;

  always_comb begin
    w_load_dur = D00;
    case (tif.TIMER_SEL)
      2'b00:   w_load_dur = D00;
      2'b01:   w_load_dur = D01;
      2'b10:   w_load_dur = D10;
      default: w_load_dur = D11;
    endcase
  end

  assign w_sel_chg = (tif.TIMER_SEL != r_sel);
  assign w_tick    = (r_presc == PS_MAX);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state  <= ST_IDLE;
      r_presc  <= '0;
      r_remain <= '0;
      r_sel    <= 2'b00;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (tif.TIMER_EN) begin
            r_state  <= ST_RUN;
            r_busy   <= 1'b1;
            r_presc  <= '0;
            r_remain <= w_load_dur;
            r_sel    <= tif.TIMER_SEL;
          end
        end

        ST_RUN: begin
          if (!tif.TIMER_EN) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_presc  <= '0;
            r_remain <= '0;
          end else if (w_sel_chg) begin
            // Abandon the current phase and time the new one from this edge.
            r_presc  <= '0;
            r_remain <= w_load_dur;
            r_sel    <= tif.TIMER_SEL;
          end else if (w_tick) begin
            r_presc <= '0;
            if (r_remain <= CNT_W'(1)) begin
              r_remain <= '0;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= ST_EXPIRED;
            end else begin
              r_remain <= r_remain - CNT_W'(1);
            end
          end else begin
            r_presc <= r_presc + PS_W'(1);
          end
        end

        ST_EXPIRED: begin
          if (!tif.TIMER_EN) begin
            r_state <= ST_IDLE;
          end else if (w_sel_chg) begin
            r_state  <= ST_RUN;
            r_busy   <= 1'b1;
            r_presc  <= '0;
            r_remain <= w_load_dur;
            r_sel    <= tif.TIMER_SEL;
          end
        end

        default: begin
          r_state  <= ST_IDLE;
          r_busy   <= 1'b0;
          r_presc  <= '0;
          r_remain <= '0;
        end
      endcase
    end
  end

  assign tif.TIMER_DONE   = r_done;
  assign tif.TIMER_BUSY   = r_busy;
  assign tif.TIMER_REMAIN = r_remain;

endmodule

// File: tb/tb_washing_machine_timer.sv
// Directed bench for washing_machine_timer with PRESCALE=4, durations 1/3/5/2 and an 8-bit counter.
module tb_washing_machine_timer;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   n_pulse = 0;
  int   p0;

  washing_machine_timer_if #(.CNT_W(8)) tif ();

  washing_machine_timer #(
    .PRESCALE(4), .CNT_W(8),
    .DUR_00(1), .DUR_01(3), .DUR_10(5), .DUR_11(2)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .tif (tif)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  // One rising edge, then settle before sampling or driving.
  task automatic step();
    @(posedge CLK);
    #1;
    if (tif.TIMER_DONE === 1'b1) n_pulse++;
  endtask

  // Steps up to exp_cyc+3 edges; expects exactly one pulse, exp_cyc edges after the start edge.
  task automatic wait_done(input string tag, input int exp_cyc);
    int first;
    int cnt;
    first = -1;
    cnt   = 0;
    for (int i = 1; i <= exp_cyc + 3; i++) begin
      step();
      if (tif.TIMER_DONE === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    chk({tag, "_done_at"}, first, exp_cyc);
    chk({tag, "_pulses"}, cnt, 1);
    chk({tag, "_remain_end"}, int'(tif.TIMER_REMAIN), 0);
    chk({tag, "_busy_end"}, int'(tif.TIMER_BUSY), 0);
  endtask

  initial begin
    tif.TIMER_EN  = 1'b1;
    tif.TIMER_SEL = 2'b01;
    RST = 1'b0;

    // 1. Reset dominates a held request
    step();
    step();
    chk("rst_done",   int'(tif.TIMER_DONE),   0);
    chk("rst_busy",   int'(tif.TIMER_BUSY),   0);
    chk("rst_remain", int'(tif.TIMER_REMAIN), 0);

    // 2. Medium wash starts at the first edge out of reset (edge 0)
    RST = 1'b1;
    step();
    chk("mw_busy0",   int'(tif.TIMER_BUSY),   1);
    chk("mw_remain0", int'(tif.TIMER_REMAIN), 3);
    for (int k = 1; k <= 12; k++) begin
      int exp_rem;
      step();
      exp_rem = (k < 4) ? 3 : (k < 8) ? 2 : (k < 12) ? 1 : 0;
      chk($sformatf("mw_remain_e%0d", k), int'(tif.TIMER_REMAIN), exp_rem);
      chk($sformatf("mw_done_e%0d", k), int'(tif.TIMER_DONE), (k == 12) ? 1 : 0);
    end
    p0 = n_pulse;
    for (int k = 0; k < 4; k++) step();
    chk("mw_hold_pulses", n_pulse - p0, 0);
    chk("mw_hold_remain", int'(tif.TIMER_REMAIN), 0);
    chk("mw_hold_busy",   int'(tif.TIMER_BUSY),   0);

    // 3. High wash, then spin after a one-cycle drop of TIMER_EN
    tif.TIMER_EN = 1'b0;
    step();
    chk("hw_idle_busy", int'(tif.TIMER_BUSY), 0);
    tif.TIMER_EN  = 1'b1;
    tif.TIMER_SEL = 2'b10;
    step();
    chk("hw_remain0", int'(tif.TIMER_REMAIN), 5);
    wait_done("hw", 20);
    tif.TIMER_EN = 1'b0;
    step();
    tif.TIMER_EN  = 1'b1;
    tif.TIMER_SEL = 2'b11;
    step();
    chk("sp_remain0", int'(tif.TIMER_REMAIN), 2);
    wait_done("sp", 8);

    // 4. Abort at edge 6 of a medium wash
    tif.TIMER_EN = 1'b0;
    step();
    tif.TIMER_EN  = 1'b1;
    tif.TIMER_SEL = 2'b01;
    step();
    for (int k = 1; k <= 5; k++) step();
    chk("ab_remain_e5", int'(tif.TIMER_REMAIN), 2);
    tif.TIMER_EN = 1'b0;
    p0 = n_pulse;
    step();
    chk("ab_busy",   int'(tif.TIMER_BUSY),   0);
    chk("ab_remain", int'(tif.TIMER_REMAIN), 0);
    for (int k = 0; k < 20; k++) step();
    chk("ab_pulses", n_pulse - p0, 0);

    // 5. Reselect 10 -> 11 at edge 7
    tif.TIMER_EN  = 1'b1;
    tif.TIMER_SEL = 2'b10;
    p0 = n_pulse;
    step();
    chk("rs_remain0", int'(tif.TIMER_REMAIN), 5);
    for (int k = 1; k <= 6; k++) step();
    chk("rs_remain_e6", int'(tif.TIMER_REMAIN), 4);
    tif.TIMER_SEL = 2'b11;
    step();
    chk("rs_remain_e7", int'(tif.TIMER_REMAIN), 2);
    chk("rs_busy_e7",   int'(tif.TIMER_BUSY),   1);
    wait_done("rs", 8);
    chk("rs_total_pulses", n_pulse - p0, 1);

    // 6. Direct phase change out of EXPIRED without dropping TIMER_EN
    tif.TIMER_EN = 1'b0;
    step();
    tif.TIMER_EN  = 1'b1;
    tif.TIMER_SEL = 2'b01;
    step();
    wait_done("dp_mw", 12);
    tif.TIMER_SEL = 2'b11;
    step();
    chk("dp_busy",   int'(tif.TIMER_BUSY),   1);
    chk("dp_remain", int'(tif.TIMER_REMAIN), 2);
    wait_done("dp_sp", 8);

    // Reset mid-run kills the run with no pulse
    tif.TIMER_EN = 1'b0;
    step();
    tif.TIMER_EN  = 1'b1;
    tif.TIMER_SEL = 2'b10;
    step();
    for (int k = 0; k < 5; k++) step();
    p0 = n_pulse;
    RST = 1'b0;
    step();
    chk("mr_busy",   int'(tif.TIMER_BUSY),   0);
    chk("mr_remain", int'(tif.TIMER_REMAIN), 0);
    tif.TIMER_EN = 1'b0;
    RST = 1'b1;
    for (int k = 0; k < 25; k++) step();
    chk("mr_pulses", n_pulse - p0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/washing_machine_timer.md
# washing_machine_timer

Programmable cycle timer that serves the washing-machine controller's timer request interface. It accepts `TIMER_EN`/`TIMER_SEL[1:0]` from the controller and returns a one-cycle `TIMER_DONE` pulse once the selected phase duration has elapsed. The controller FSM uses this pulse to advance from wash (medium or high level) to drain, and from spin to end. A built-in prescaler converts clock cycles into time units, and a down-counter tracks the remaining units.

## Interface
- `PRESCALE`, 50: clock cycles per time unit; must be ≥1.
- `CNT_W`, 16: width of the remaining-units counter.
- `DUR_00`, 1: duration in units for `TIMER_SEL`=00 (reserved/short).
- `DUR_01`, 600: duration for 01, medium-level wash.
- `DUR_10`, 900: duration for 10, high-level wash.
- `DUR_11`, 300: duration for 11, spin.

Ports:
- `CLK`  in  1  system clock; all logic is rising-edge.
- `RST`  in  1  synchronous, active-low reset.
- `TIMER_EN`  in  1  timer request, held high by the controller for the whole timed phase.
- `TIMER_SEL`  in  2  phase select, sampled when a run starts.
- `TIMER_DONE`  out  1  one-cycle pulse when the selected duration expires.
- `TIMER_BUSY`  out  1  high while in RUN.
- `TIMER_REMAIN`  out  CNT_W  remaining time units; 0 when not running.

## Operation
Reset: at a rising `CLK` edge with `RST`=0:
- state goes to IDLE;
- `TIMER_DONE`, `TIMER_BUSY` and `TIMER_REMAIN` go to 0;
- the prescaler goes to 0 and latched select `sel_q` goes to 00.

Reset takes priority over every other event, including reset in the middle of a run; no `TIMER_DONE` is produced for an interrupted run.

Durations:
- The selected `DUR_xx` is truncated to `CNT_W` bits.
- A duration of 0 is treated as 1.

State machine. "Load" means: `TIMER_REMAIN`=DUR(`TIMER_SEL`), prescaler=0, `sel_q`=`TIMER_SEL`, go to RUN.
- **IDLE**
  - `TIMER_EN`=1: load.
  - Otherwise stay in IDLE.
- **RUN**
  - `TIMER_EN`=0: abort. Go to IDLE, `TIMER_REMAIN`=0, no `TIMER_DONE`.
  - `TIMER_SEL`≠`sel_q`: restart, i.e. load with the new select. No `TIMER_DONE` for the abandoned run.
  - Otherwise, when the prescaler = `PRESCALE`-1 (a tick): prescaler→0 and `TIMER_REMAIN` decrements. On all other cycles the prescaler increments.
  - On a tick with `TIMER_REMAIN`=1: `TIMER_REMAIN`→0, `TIMER_DONE`=1 for that single cycle, go to EXPIRED.
- **EXPIRED**
  - `TIMER_EN`=0: go to IDLE.
  - `TIMER_EN`=1 and `TIMER_SEL`≠`sel_q`: load. This covers the controller moving straight to a new timed phase without dropping `TIMER_EN`.
  - Otherwise hold, with no further pulses.

Priority within RUN: reset, then abort, then select-change restart, then tick.

Other rules:
- `TIMER_BUSY` = (state==RUN).
- `TIMER_DONE` is registered and never high for two consecutive cycles.
- The counter never wraps: decrement happens only from a value ≥1.

## Timing
- A request sampled at edge N (IDLE, `TIMER_EN`=1) gives, from that edge onward:
  - `TIMER_BUSY`=1;
  - `TIMER_REMAIN`=D, where D is the effective duration.
- Tick k occurs at edge N+k·`PRESCALE`, and `TIMER_REMAIN`=D−k after it.
- `TIMER_DONE` is high for exactly one cycle after edge N+D·`PRESCALE`. `TIMER_BUSY` falls at that same edge.
- With `PRESCALE`=1, a tick occurs every cycle. With D=1, `PRESCALE`=1, `TIMER_DONE` follows after edge N+1.
- Abort and restart take effect at the edge where the condition is sampled.
- A restart resets both the prescaler and the counter, so the full new duration elapses from that edge.
- Minimum EXPIRED→IDLE→RUN turnaround: EXPIRED at edge M, `TIMER_EN` low sampled at M+1, new start sampled at M+2 or later.

## Test plan
Bench setting: `PRESCALE`=4, `DUR_01`=3, `DUR_10`=5, `DUR_11`=2, `CNT_W`=8.

1. Reset: hold `RST`=0 for 2 cycles with `TIMER_EN`=1 → `TIMER_DONE`=0, `TIMER_BUSY`=0, `TIMER_REMAIN`=0. Release `RST` → a run starts at the first edge with `RST`=1.
2. Medium wash: `TIMER_SEL`=01, `TIMER_EN`=1 sampled at edge 0 → `TIMER_REMAIN` reads 3,2,1 after edges 0,4,8. `TIMER_DONE`=1 only after edge 12. `TIMER_REMAIN`=0 and state EXPIRED with no further pulse while `TIMER_EN` stays high.
3. High wash then spin: select 10 → `TIMER_DONE` after edge 20. Drop `TIMER_EN` for 1 cycle, then start with select 11 → `TIMER_DONE` 8 cycles after the new start edge.
4. Abort: select 01, drop `TIMER_EN` at edge 6 → `TIMER_BUSY`=0 and `TIMER_REMAIN`=0 from edge 6. No `TIMER_DONE` within the next 20 cycles.
5. Reselect mid-run: start with select 10, switch to 11 at edge 7 → `TIMER_REMAIN`=2 after edge 7. `TIMER_DONE` after edge 15, and only one pulse total.
6. Direct phase change: after expiry with select 01 and `TIMER_EN` held high, change `TIMER_SEL` to 11 → reload at the next edge, and `TIMER_DONE` 8 cycles later.
